// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction-fetch credit logic: FSM state
// encoding and the default buffer/in-flight limits.
package ifetch_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fetch_state_e;

    localparam int IBUF_DEPTH     = 8;
    localparam int IFETCH_MAX_OUT = 2;

endpackage

// File: rtl/sat_updown_cnt.sv
// Up/down counter with synchronous clear that saturates at 0 and at MAX.
// Simultaneous up and down leave the count unchanged.
module sat_updown_cnt #(
    parameter int WIDTH = 4,
    parameter int MAX   = (1 << WIDTH) - 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             up,
    input  logic             down,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (up && !down && count != MAX_V) begin
            count <= count + WIDTH'(1);
        end else if (down && !up && count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

endmodule

// File: rtl/fetch_credit_ctrl.sv
// Credit-based icache fetch throttle with flush drain of stale responses.
// Optional perf counters are built when FETCH_CREDIT_PERF_EN is defined.
//
// state | meaning
// RUN   | normal operation: issue fetches against buffer credit, push returns
// DRAIN | after a flush: wait for stale in-flight returns, discard them all
module fetch_credit_ctrl
    import ifetch_pkg::*;
#(
    parameter int DEPTH   = IBUF_DEPTH,
    parameter int MAX_OUT = IFETCH_MAX_OUT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    output logic                         fetch_req,
    input  logic                         fetch_ack,
    input  logic                         icache_valid,
    output logic                         push_en,
    input  logic                         pop_en,
    output logic                         buf_flush,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic [$clog2(MAX_OUT+1)-1:0] outstanding,
    output logic                         draining,
    output logic                         proto_err
`ifdef FETCH_CREDIT_PERF_EN
    ,
    output logic [31:0]                  perf_stall_cyc,
    output logic [31:0]                  perf_discard
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUT + 1);
    localparam logic [31:0] DEPTH_U   = 32'(DEPTH);
    localparam logic [31:0] MAX_OUT_U = 32'(MAX_OUT);

    fetch_state_e state, state_nxt;

    logic credit_ok;
    logic fetch_fire;
    logic ret_ok;
    logic outs_next_zero;

    // Buffer slots already promised to in-flight fetches count against credit.
    assign credit_ok = ((32'(occupancy) + 32'(outstanding)) < DEPTH_U)
                    && (32'(outstanding) < MAX_OUT_U);

    assign fetch_req  = !rst && (state == RUN) && !flush && credit_ok;
    assign push_en    = !rst && icache_valid && (state == RUN) && !flush
                     && (outstanding != '0);
    assign buf_flush  = flush;
    assign draining   = (state == DRAIN);

    assign fetch_fire = fetch_req && fetch_ack;
    assign ret_ok     = icache_valid && (outstanding != '0);

    assign outs_next_zero = (fetch_fire == ret_ok) ? (outstanding == '0)
                          : (ret_ok && outstanding == OW'(1));

    sat_updown_cnt #(
        .WIDTH (CW),
        .MAX   (DEPTH)
    ) u_occ_cnt (
        .clk   (clk),
        .clr   (rst || flush),
        .up    (push_en),
        .down  (pop_en),
        .count (occupancy)
    );

    sat_updown_cnt #(
        .WIDTH (OW),
        .MAX   (MAX_OUT)
    ) u_out_cnt (
        .clk   (clk),
        .clr   (rst),
        .up    (fetch_fire),
        .down  (ret_ok),
        .count (outstanding)
    );

    // Leaving DRAIN wins over a repeated flush: with nothing in flight there
    // is nothing left to discard and no fetch could ever be issued.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (flush && !outs_next_zero) state_nxt = DRAIN;
            DRAIN:   if (outs_next_zero)           state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            proto_err <= 1'b0;
        end else if ((icache_valid && outstanding == '0) || (fetch_ack && !fetch_req)) begin
            proto_err <= 1'b1;
        end
    end

`ifdef FETCH_CREDIT_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cyc <= '0;
            perf_discard   <= '0;
        end else begin
            if (state == RUN && !fetch_req) perf_stall_cyc <= perf_stall_cyc + 32'd1;
            if (state == DRAIN && icache_valid) perf_discard <= perf_discard + 32'd1;
        end
    end
`endif

endmodule

// File: doc/fetch_credit_ctrl.md
FETCH_CREDIT_CTRL -- requirements
Module: fetch_credit_ctrl

Interface
REQ-001 Parameter: DEPTH, default 8, capacity of the downstream instruction buffer in instruction-pair entries.
REQ-002 Parameter: MAX_OUT, default 2, maximum number of icache fetches in flight.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: flush  input  1  pipeline redirect; all buffered and in-flight fetches are now stale.
REQ-006 Port: fetch_req  output  1  request the next instruction pair from the icache.
REQ-007 Port: fetch_ack  input  1  icache accepted fetch_req this cycle.
REQ-008 Port: icache_valid  input  1  icache returns one pair this cycle.
REQ-009 Port: push_en  output  1  write the returned pair into the instruction buffer.
REQ-010 Port: pop_en  input  1  decode consumes one pair from the buffer.
REQ-011 Port: buf_flush  output  1  clear the instruction buffer.
REQ-012 Port: occupancy  output  $clog2(DEPTH+1)  pairs currently held in the buffer.
REQ-013 Port: outstanding  output  $clog2(MAX_OUT+1)  fetches accepted but not yet returned.
REQ-014 Port: draining  output  1  high while the block is in the DRAIN state.
REQ-015 Port: proto_err  output  1  sticky flag for an icache protocol violation.

Function
REQ-016 The block SHALL have two states, RUN and DRAIN.
REQ-017 fetch_req SHALL be high exactly when all of these hold: state is RUN, flush is low, occupancy+outstanding < DEPTH, and outstanding < MAX_OUT.
REQ-018 push_en SHALL be high exactly when all of these hold: icache_valid is high, state is RUN, flush is low, and outstanding > 0.
REQ-019 buf_flush SHALL equal flush combinationally, with zero-cycle latency.
REQ-020 occupancy SHALL update on each rising edge as follows:
- +1 on push_en alone.
- -1 on pop_en alone when occupancy > 0.
- Unchanged on simultaneous push_en and pop_en.
- pop_en when occupancy is 0: ignored.
REQ-021 On flush, occupancy SHALL be 0 in the next cycle; flush overrides any push or pop in the same cycle.
REQ-022 outstanding SHALL update on each rising edge as follows:
- +1 on fetch_req&fetch_ack alone.
- -1 on icache_valid alone when outstanding > 0.
- Unchanged when both occur.
- flush does not clear it.
REQ-023 icache_valid while outstanding is 0 SHALL be ignored and SHALL set proto_err; proto_err SHALL be cleared only by rst.
REQ-024 fetch_ack while fetch_req is low SHALL be ignored and SHALL set proto_err.
REQ-025 RUN to DRAIN: on flush, when the next value of outstanding is nonzero.
REQ-026 RUN to RUN: on flush, when the next value of outstanding is zero.
REQ-027 In DRAIN, every icache_valid SHALL be discarded: push_en stays low and outstanding decrements.
REQ-028 DRAIN to RUN: on the edge where outstanding becomes 0.
REQ-029 A flush received in DRAIN SHALL keep the block in DRAIN; the counters follow their normal rules.
REQ-030 fetch_req SHALL be low for the whole of DRAIN, so no new fetch is issued before the stale responses have all returned.
REQ-031 draining SHALL be high exactly when state is DRAIN.

Reset
REQ-032 While rst is high on a rising edge, the following SHALL hold in the next cycle: state RUN, occupancy 0, outstanding 0, proto_err 0.
REQ-033 While rst is high, fetch_req and push_en SHALL be forced low.
REQ-034 rst SHALL take priority over flush and over every handshake input; rst asserted mid-DRAIN SHALL return the block to RUN with zeroed counters.

Configuration
REQ-035 With macro FETCH_CREDIT_PERF_EN defined, the block SHALL provide two 32-bit wrapping counters, both cleared by rst:
- perf_stall_cyc output: counts cycles in which state is RUN and fetch_req is low.
- perf_discard output: counts icache_valid responses discarded in DRAIN.
REQ-036 Without FETCH_CREDIT_PERF_EN, neither counter port SHALL exist and the counter logic SHALL be absent.

Structure
REQ-037 Shared package ifetch_pkg SHALL hold:
- the state enum (RUN, DRAIN);
- the default constants IBUF_DEPTH=8 and IFETCH_MAX_OUT=2.
REQ-038 Sub-module sat_updown_cnt SHALL be instantiated twice, once for occupancy and once for outstanding. It SHALL be a parameterised width up/down counter with:
- synchronous clear;
- saturation at 0 and at its maximum.

Verification
REQ-039 Fill: reset, then hold fetch_ack=1, icache_valid one cycle after each ack, pop_en=0 -> occupancy rises to 8 and fetch_req drops when occupancy+outstanding=8; push_en never fires with occupancy=8.
REQ-040 Steady state: pop_en=1 and push_en=1 in the same cycle at occupancy=5 -> occupancy stays 5.
REQ-041 Flush with 2 in flight: flush at outstanding=2, occupancy=4 ->
- next cycle: occupancy=0 and draining=1;
- the next two icache_valid pulses give push_en=0;
- draining drops on the edge where outstanding reaches 0;
- fetch_req resumes the following cycle.
REQ-042 Flush on the same cycle as the last return: flush with outstanding=1 and icache_valid=1 -> state stays RUN, push_en=0, outstanding=0.
REQ-043 Protocol error: icache_valid=1 with outstanding=0 -> outstanding stays 0, proto_err=1, and proto_err stays 1 until rst.
REQ-044 Reset mid-DRAIN: rst during DRAIN with outstanding=1 -> next cycle draining=0, outstanding=0, occupancy=0; with FETCH_CREDIT_PERF_EN defined, perf_discard=0.
